// File: rtl/fpga_rst_seq_if.sv
// Sequencer bus: lock/request inputs and reset/status outputs.
// The slave side is the sequencer; the master side is the board top.
interface fpga_rst_seq_if;
   logic       pll_locked_i;
   logic       sw_rst_req_i;
   logic       core_rst_no;
   logic       jtag_trst_no;
   logic [2:0] seq_state_o;
   logic       lock_lost_o;
   logic [7:0] sw_rst_cnt_o;
   logic       heartbeat_o;

   modport master (
      output pll_locked_i,
      output sw_rst_req_i,
      input  core_rst_no,
      input  jtag_trst_no,
      input  seq_state_o,
      input  lock_lost_o,
      input  sw_rst_cnt_o,
      input  heartbeat_o
   );

   modport slave (
      input  pll_locked_i,
      input  sw_rst_req_i,
      output core_rst_no,
      output jtag_trst_no,
      output seq_state_o,
      output lock_lost_o,
      output sw_rst_cnt_o,
      output heartbeat_o
   );
endinterface

// File: rtl/fpga_rst_seq.sv
// Reset/boot sequencer: debounces PLL lock, then releases TAP and
// core resets in order; handles lock loss, sw resets and heartbeat.
module fpga_rst_seq #(
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int CORE_RST_HOLD      = 64,
   parameter int SW_RST_HOLD        = 16,
   parameter int HEARTBEAT_DIV      = 25000000
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   fpga_rst_seq_if.slave  bus
);

   localparam int M0 = (LOCK_STABLE_CYCLES > CORE_RST_HOLD) ?
                       LOCK_STABLE_CYCLES : CORE_RST_HOLD;
   localparam int M1 = (M0 > SW_RST_HOLD) ? M0 : SW_RST_HOLD;
   localparam int MP = (M1 > HEARTBEAT_DIV) ? M1 : HEARTBEAT_DIV;
   localparam int CW = $clog2(MP) + 1;

   localparam logic [CW-1:0] LS_END = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0] CH_END = CW'(CORE_RST_HOLD - 1);
   localparam logic [CW-1:0] SW_END = CW'(SW_RST_HOLD - 1);
   localparam logic [CW-1:0] HB_END = CW'(HEARTBEAT_DIV - 1);

   typedef enum logic [2:0] {
      WAIT_LOCK = 3'd0,
      STABLE    = 3'd1,
      HOLD      = 3'd2,
      RUN       = 3'd3,
      SW_RST    = 3'd4
   } state_e;

   state_e        state_q, state_n;
   logic [CW-1:0] cnt_q, cnt_n;
   logic [CW-1:0] hb_cnt_q, hb_cnt_n;
   logic          hb_q, hb_n;
   logic          sync1_q, lock_s;
   logic          core_q, jtag_q;
   logic          lost_q, lost_n;
   logic [7:0]    sw_cnt_q, sw_cnt_n;
   logic          sw_acc;
   logic          lost_ev;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync1_q <= 1'b0;
         lock_s  <= 1'b0;
      end else begin
         sync1_q <= bus.pll_locked_i;
         lock_s  <= sync1_q;
      end
   end

   // Lock loss is checked first in every locked state, so it wins
   // over counter expiry and over a coincident sw request.
   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      sw_acc  = 1'b0;
      lost_ev = 1'b0;
      case (state_q)
         WAIT_LOCK: begin
            cnt_n = '0;
            if (lock_s) state_n = STABLE;
         end
         STABLE: begin
            if (!lock_s) begin
               state_n = WAIT_LOCK;
               cnt_n   = '0;
            end else if (cnt_q == LS_END) begin
               state_n = HOLD;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         HOLD: begin
            if (!lock_s) begin
               state_n = WAIT_LOCK;
               cnt_n   = '0;
            end else if (cnt_q == CH_END) begin
               state_n = RUN;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         RUN: begin
            if (!lock_s) begin
               state_n = WAIT_LOCK;
               cnt_n   = '0;
               lost_ev = 1'b1;
            end else if (bus.sw_rst_req_i) begin
               state_n = SW_RST;
               cnt_n   = '0;
               sw_acc  = 1'b1;
            end
         end
         SW_RST: begin
            if (!lock_s) begin
               state_n = WAIT_LOCK;
               cnt_n   = '0;
               lost_ev = 1'b1;
            end else if (cnt_q == SW_END) begin
               state_n = RUN;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         default: begin
            state_n = WAIT_LOCK;
            cnt_n   = '0;
         end
      endcase
   end

   // Divider only advances while staying in RUN; entry restarts it.
   always_comb begin
      hb_cnt_n = '0;
      hb_n     = 1'b0;
      if (state_n == RUN && state_q == RUN) begin
         if (hb_cnt_q == HB_END) begin
            hb_cnt_n = '0;
            hb_n     = ~hb_q;
         end else begin
            hb_cnt_n = hb_cnt_q + 1'b1;
            hb_n     = hb_q;
         end
      end
   end

   always_comb begin
      sw_cnt_n = sw_cnt_q;
      if (sw_acc && sw_cnt_q != 8'hFF) sw_cnt_n = sw_cnt_q + 8'd1;
      lost_n = lost_q | lost_ev;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= WAIT_LOCK;
         cnt_q    <= '0;
         hb_cnt_q <= '0;
         hb_q     <= 1'b0;
         core_q   <= 1'b0;
         jtag_q   <= 1'b0;
         lost_q   <= 1'b0;
         sw_cnt_q <= 8'd0;
      end else begin
         state_q  <= state_n;
         cnt_q    <= cnt_n;
         hb_cnt_q <= hb_cnt_n;
         hb_q     <= hb_n;
         core_q   <= (state_n == RUN);
         jtag_q   <= (state_n == HOLD) || (state_n == RUN) ||
                     (state_n == SW_RST);
         lost_q   <= lost_n;
         sw_cnt_q <= sw_cnt_n;
      end
   end

   assign bus.core_rst_no  = core_q;
   assign bus.jtag_trst_no = jtag_q;
   assign bus.seq_state_o  = state_q;
   assign bus.lock_lost_o  = lost_q;
   assign bus.sw_rst_cnt_o = sw_cnt_q;
   assign bus.heartbeat_o  = hb_q;

endmodule

// File: tb/tb_fpga_rst_seq.sv
// Directed bench for fpga_rst_seq with small parameters
// (8/4/3/5); expected values are hand-derived edge timings.
module tb_fpga_rst_seq;
   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;

   fpga_rst_seq_if bus_if ();

   fpga_rst_seq #(
      .LOCK_STABLE_CYCLES (8),
      .CORE_RST_HOLD      (4),
      .SW_RST_HOLD        (3),
      .HEARTBEAT_DIV      (5)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_run(input string tag);
      int n;
      n = 0;
      while (bus_if.seq_state_o != 3'd3 && n < 40) begin
         tick();
         n++;
      end
      chk(tag, bus_if.seq_state_o, 3);
   endtask

   task automatic chk_rst_vals(input string tag);
      chk({tag, "_core"}, bus_if.core_rst_no, 0);
      chk({tag, "_jtag"}, bus_if.jtag_trst_no, 0);
      chk({tag, "_state"}, bus_if.seq_state_o, 0);
      chk({tag, "_lost"}, bus_if.lock_lost_o, 0);
      chk({tag, "_swcnt"}, bus_if.sw_rst_cnt_o, 0);
      chk({tag, "_hb"}, bus_if.heartbeat_o, 0);
   endtask

   function automatic int boot_state(int e);
      if (e < 2) return 0;
      if (e < 10) return 1;
      if (e < 14) return 2;
      return 3;
   endfunction

   function automatic int glitch_state(int e);
      if (e < 2) return 0;
      if (e <= 6) return 1;
      if (e == 7) return 0;
      if (e < 16) return 1;
      if (e < 20) return 2;
      return 3;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      bus_if.pll_locked_i = 1'b0;
      bus_if.sw_rst_req_i = 1'b0;
      repeat (3) tick();
      chk_rst_vals("reset");
      rst_n = 1'b1;
      repeat (2) tick();
      chk("idle_state", bus_if.seq_state_o, 0);

      // cold boot; edge 0 is the first edge sampling lock high
      bus_if.pll_locked_i = 1'b1;
      for (int e = 0; e <= 30; e++) begin
         tick();
         chk($sformatf("boot_state[%0d]", e), bus_if.seq_state_o,
             boot_state(e));
         chk($sformatf("boot_jtag[%0d]", e), bus_if.jtag_trst_no,
             (e >= 10) ? 1 : 0);
         chk($sformatf("boot_core[%0d]", e), bus_if.core_rst_no,
             (e >= 14) ? 1 : 0);
         chk($sformatf("boot_hb[%0d]", e), bus_if.heartbeat_o,
             (e < 14) ? 0 : ((e - 14) / 5) % 2);
      end

      // glitchy lock: low sample at edge 5 only
      rst_n = 1'b0;
      bus_if.pll_locked_i = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      for (int e = 0; e <= 21; e++) begin
         bus_if.pll_locked_i = (e == 5) ? 1'b0 : 1'b1;
         tick();
         chk($sformatf("gl_state[%0d]", e), bus_if.seq_state_o,
             glitch_state(e));
         chk($sformatf("gl_core[%0d]", e), bus_if.core_rst_no,
             (e >= 20) ? 1 : 0);
      end
      chk("gl_lost", bus_if.lock_lost_o, 0);

      // software reset, plus an ignored second pulse in SW_RST
      for (int k = 0; k <= 8; k++) begin
         bus_if.sw_rst_req_i = (k == 0 || k == 2) ? 1'b1 : 1'b0;
         tick();
         chk($sformatf("sw_state[%0d]", k), bus_if.seq_state_o,
             (k < 3) ? 4 : 3);
         chk($sformatf("sw_core[%0d]", k), bus_if.core_rst_no,
             (k < 3) ? 0 : 1);
         chk($sformatf("sw_jtag[%0d]", k), bus_if.jtag_trst_no, 1);
         chk($sformatf("sw_cnt[%0d]", k), bus_if.sw_rst_cnt_o, 1);
         chk($sformatf("sw_hb[%0d]", k), bus_if.heartbeat_o,
             (k == 8) ? 1 : 0);
      end
      bus_if.sw_rst_req_i = 1'b0;

      // lock loss in RUN with a coincident sw request
      bus_if.pll_locked_i = 1'b0;
      tick();
      chk("ll_state_a0", bus_if.seq_state_o, 3);
      tick();
      chk("ll_state_a1", bus_if.seq_state_o, 3);
      bus_if.sw_rst_req_i = 1'b1;
      tick();
      bus_if.sw_rst_req_i = 1'b0;
      chk("ll_state", bus_if.seq_state_o, 0);
      chk("ll_core", bus_if.core_rst_no, 0);
      chk("ll_jtag", bus_if.jtag_trst_no, 0);
      chk("ll_lost", bus_if.lock_lost_o, 1);
      chk("ll_swcnt", bus_if.sw_rst_cnt_o, 1);
      chk("ll_hb", bus_if.heartbeat_o, 0);

      // relock, heartbeat, then reset pulse mid-RUN
      bus_if.pll_locked_i = 1'b1;
      wait_run("relock_run");
      chk("relock_lost", bus_if.lock_lost_o, 1);
      repeat (4) tick();
      chk("hb_pre", bus_if.heartbeat_o, 0);
      tick();
      chk("hb_toggle", bus_if.heartbeat_o, 1);
      rst_n = 1'b0;
      tick();
      chk_rst_vals("midrun_rst");
      rst_n = 1'b1;

      // saturation of the software reset counter
      wait_run("sat_run");
      for (int i = 1; i <= 300; i++) begin
         bus_if.sw_rst_req_i = 1'b1;
         tick();
         bus_if.sw_rst_req_i = 1'b0;
         repeat (3) tick();
         if (i == 100) chk("sat_cnt100", bus_if.sw_rst_cnt_o, 100);
         if (i == 255) chk("sat_cnt255", bus_if.sw_rst_cnt_o, 255);
      end
      chk("sat_cnt300", bus_if.sw_rst_cnt_o, 255);
      chk("sat_state", bus_if.seq_state_o, 3);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
